// File: rtl/spi_slave_if.sv
// SPI responder: shifts a word out on miso_o while shifting a word in from mosi_i.
// All SPI pins are brought into clk_i through synchronizers, and the serial
// protocol then runs from edges detected on the synchronized sclk.
module spi_slave_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  sclk_i,
  input  logic                  ss_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  rx_done_tick_o,
  output logic                  abort_tick_o,
  output logic                  busy_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    ss_prev_q, ss_prev_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    miso_q, miso_d;
  logic                    fresh_q, fresh_d;
  logic                    rx_done_q, rx_done_d;
  logic                    abort_q, abort_d;

  logic                    sclk_s, ss_s, mosi_s;
  logic                    lead_edge, trail_edge, sample_edge, drive_edge;
  logic                    ss_fall, word_end, load_now;
  logic [DATA_WIDTH-1:0]   load_word, rx_next, tx_shifted;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != cpol_i);
  assign trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == cpol_i);
  assign sample_edge = cpha_i ? trail_edge : lead_edge;
  assign drive_edge  = cpha_i ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q && !ss_s;
  assign word_end    = (state_q == SHIFT) && sample_edge && (cnt_q == LAST_BIT);
  // A shifter load happens in LOAD and at each word end while still selected.
  assign load_now    = (state_q == LOAD) || (word_end && !ss_s);
  assign load_word   = hold_valid_q ? hold_q : '0;
  assign rx_next     = (rx_q << 1) | DATA_WIDTH'(mosi_s);
  assign tx_shifted  = tx_q << 1;

  assign din_ready_o    = !hold_valid_q && !load_now;
  assign miso_o         = miso_q;
  assign miso_oe_o      = (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);
  assign dout_o         = dout_q;
  assign rx_done_tick_o = rx_done_q;
  assign abort_tick_o   = abort_q;

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      tx_q         <= '0;
      rx_q         <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      dout_q       <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      fresh_q      <= 1'b0;
      rx_done_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      ss_prev_q    <= ss_prev_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      dout_q       <= dout_d;
      cnt_q        <= cnt_d;
      miso_q       <= miso_d;
      fresh_q      <= fresh_d;
      rx_done_q    <= rx_done_d;
      abort_q      <= abort_d;
    end
  end

  // Synchronizer chains plus the one-cycle history used for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_ni};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Next-state logic: select starts a frame, deselect always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = LOAD;
      LOAD:    state_d = ss_s ? IDLE : SHIFT;
      SHIFT:   if (ss_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifters, bit counter, holding register and the tick outputs.
  always_comb begin
    tx_d         = tx_q;
    rx_d         = rx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    dout_d       = dout_q;
    cnt_d        = cnt_q;
    miso_d       = miso_q;
    fresh_d      = fresh_q;
    rx_done_d    = 1'b0;
    abort_d      = 1'b0;

    if (din_valid_i && din_ready_o) begin
      hold_d       = din_i;
      hold_valid_d = 1'b1;
    end else if (load_now) begin
      hold_d       = '0;
      hold_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d  = 1'b0;
        cnt_d   = '0;
        fresh_d = 1'b0;
      end
      LOAD: begin
        tx_d    = load_word;
        rx_d    = '0;
        cnt_d   = '0;
        fresh_d = 1'b0;
        miso_d  = (!cpha_i && !ss_s) ? load_word[DATA_WIDTH-1] : 1'b0;
      end
      SHIFT: begin
        if (sample_edge) begin
          rx_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            dout_d    = rx_next;
            rx_done_d = 1'b1;
            cnt_d     = '0;
            if (!ss_s) begin
              tx_d    = load_word;
              fresh_d = !cpha_i;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (drive_edge) begin
          if (cpha_i) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_shifted;
          end else if (fresh_q) begin
            miso_d  = tx_q[DATA_WIDTH-1];
            fresh_d = 1'b0;
          end else begin
            miso_d = tx_shifted[DATA_WIDTH-1];
            tx_d   = tx_shifted;
          end
        end
        if (ss_s) begin
          miso_d  = 1'b0;
          cnt_d   = '0;
          abort_d = (cnt_q != '0) && !word_end;
        end
      end
      default: begin
        miso_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a behavioural SPI master drives the pins and
// every expected value is a hand-computed constant checked with an immediate assertion.
module tb_spi_slave_if;

  localparam int HALF = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cpol_i, cpha_i, sclk_i, ss_ni, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] din_i;
  logic       din_valid_i, din_ready_o;
  logic [7:0] dout_o;
  logic       rx_done_tick_o, abort_tick_o, busy_o;

  int checks     = 0;
  int failures   = 0;
  int rxTicks    = 0;
  int abortTicks = 0;

  spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cpol_i         (cpol_i),
    .cpha_i         (cpha_i),
    .sclk_i         (sclk_i),
    .ss_ni          (ss_ni),
    .mosi_i         (mosi_i),
    .miso_o         (miso_o),
    .miso_oe_o      (miso_oe_o),
    .din_i          (din_i),
    .din_valid_i    (din_valid_i),
    .din_ready_o    (din_ready_o),
    .dout_o         (dout_o),
    .rx_done_tick_o (rx_done_tick_o),
    .abort_tick_o   (abort_tick_o),
    .busy_o         (busy_o)
  );

  // 100 MHz system clock.
  always #5 clk_i = ~clk_i;

  // Count tick pulses so each scenario can check how many it produced.
  always @(posedge clk_i) begin
    if (rx_done_tick_o) rxTicks++;
    if (abort_tick_o) abortTicks++;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic setMode(input int mode);
    cpol_i = mode[1];
    cpha_i = mode[0];
    sclk_i = mode[1];
    waitCycles(8);
  endtask

  task automatic writeHold(input logic [7:0] value);
    int guard;
    guard = 0;
    while (din_ready_o !== 1'b1 && guard < 20000) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("hold_ready_wait", {31'd0, guard < 20000}, 32'd1);
    din_i       = value;
    din_valid_i = 1'b1;
    @(negedge clk_i);
    din_valid_i = 1'b0;
  endtask

  task automatic ssLow();
    ss_ni = 1'b0;
    waitCycles(HALF);
  endtask

  task automatic ssHigh();
    waitCycles(HALF);
    ss_ni = 1'b1;
    waitCycles(8);
  endtask

  // Master side of nBits of a transfer, MSB first, in the current cpol/cpha mode.
  task automatic applyStimulus(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
    rxByte = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      if (!cpha_i) begin
        mosi_i = txByte[7-i];
        waitCycles(HALF);
        sclk_i = ~cpol_i;
        rxByte = {rxByte[6:0], miso_o};
        waitCycles(HALF);
        sclk_i = cpol_i;
      end else begin
        sclk_i = ~cpol_i;
        mosi_i = txByte[7-i];
        waitCycles(HALF);
        rxByte = {rxByte[6:0], miso_o};
        sclk_i = cpol_i;
        waitCycles(HALF);
      end
    end
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_miso"}, {31'd0, miso_o}, 32'd0);
    checkOutput({phase, "_miso_oe"}, {31'd0, miso_oe_o}, 32'd0);
    checkOutput({phase, "_din_ready"}, {31'd0, din_ready_o}, 32'd1);
    checkOutput({phase, "_dout"}, {24'd0, dout_o}, 32'd0);
    checkOutput({phase, "_busy"}, {31'd0, busy_o}, 32'd0);
    checkOutput({phase, "_rx_tick"}, {31'd0, rx_done_tick_o}, 32'd0);
    checkOutput({phase, "_abort_tick"}, {31'd0, abort_tick_o}, 32'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    logic [7:0] r0, r1, r2;
    int ticksBefore, abortsBefore;

    rst_ni = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; sclk_i = 1'b0;
    ss_ni = 1'b1; mosi_i = 1'b0; din_i = 8'h00; din_valid_i = 1'b0;
    waitCycles(4);
    checkResetValues("reset");
    rst_ni = 1'b1;
    waitCycles(4);

    $display("[TB] mode 0 frame, holding 0xA5, master sends 0x3C");
    setMode(0);
    writeHold(8'hA5);
    ticksBefore = rxTicks;
    ssLow();
    checkOutput("m0_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("m0_miso_oe", {31'd0, miso_oe_o}, 32'd1);
    applyStimulus(8'h3C, 8, r0);
    ssHigh();
    checkOutput("m0_master_rx", {24'd0, r0}, 32'hA5);
    checkOutput("m0_dout", {24'd0, dout_o}, 32'h3C);
    checkOutput("m0_ticks", rxTicks - ticksBefore, 32'd1);
    checkOutput("m0_idle_oe", {31'd0, miso_oe_o}, 32'd0);

    for (int m = 1; m < 4; m++) begin
      $display("[TB] mode %0d frame, holding 0x81, master sends 0x7E", m);
      setMode(m);
      writeHold(8'h81);
      ssLow();
      applyStimulus(8'h7E, 8, r0);
      ssHigh();
      checkOutput($sformatf("mode%0d_master_rx", m), {24'd0, r0}, 32'h81);
      checkOutput($sformatf("mode%0d_dout", m), {24'd0, dout_o}, 32'h7E);
    end

    $display("[TB] three words in one frame, refill after first load only");
    setMode(0);
    writeHold(8'h11);
    ticksBefore  = rxTicks;
    abortsBefore = abortTicks;
    fork
      begin
        ssLow();
        applyStimulus(8'hA1, 8, r0);
        applyStimulus(8'hB2, 8, r1);
        applyStimulus(8'hC3, 8, r2);
        ssHigh();
      end
      writeHold(8'h22);
    join
    checkOutput("multi_word0", {24'd0, r0}, 32'h11);
    checkOutput("multi_word1", {24'd0, r1}, 32'h22);
    checkOutput("multi_word2", {24'd0, r2}, 32'h00);
    checkOutput("multi_dout", {24'd0, dout_o}, 32'hC3);
    checkOutput("multi_ticks", rxTicks - ticksBefore, 32'd3);
    checkOutput("multi_no_abort", abortTicks - abortsBefore, 32'd0);

    $display("[TB] deselect after four bits");
    writeHold(8'h99);
    ticksBefore  = rxTicks;
    abortsBefore = abortTicks;
    ssLow();
    applyStimulus(8'hF0, 4, r0);
    ssHigh();
    checkOutput("abort_ticks", abortTicks - abortsBefore, 32'd1);
    checkOutput("abort_no_rx", rxTicks - ticksBefore, 32'd0);
    checkOutput("abort_dout_kept", {24'd0, dout_o}, 32'hC3);
    checkOutput("abort_idle_busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] empty holding register at word start");
    ssLow();
    applyStimulus(8'h55, 8, r0);
    ssHigh();
    checkOutput("empty_master_rx", {24'd0, r0}, 32'h00);
    checkOutput("empty_dout", {24'd0, dout_o}, 32'h55);

    $display("[TB] holding register protected while full");
    writeHold(8'h5A);
    din_i       = 8'hFF;
    din_valid_i = 1'b1;
    waitCycles(5);
    checkOutput("full_ready_low", {31'd0, din_ready_o}, 32'd0);
    din_valid_i = 1'b0;
    ssLow();
    applyStimulus(8'h0F, 8, r0);
    ssHigh();
    checkOutput("full_no_overwrite", {24'd0, r0}, 32'h5A);

    $display("[TB] reset mid-word, then a clean mode 0 frame");
    writeHold(8'h77);
    ssLow();
    applyStimulus(8'hAA, 3, r0);
    rst_ni = 1'b0;
    waitCycles(2);
    checkResetValues("midreset");
    ss_ni  = 1'b1;
    sclk_i = 1'b0;
    waitCycles(4);
    rst_ni = 1'b1;
    waitCycles(8);
    writeHold(8'h3C);
    ticksBefore = rxTicks;
    ssLow();
    applyStimulus(8'hC3, 8, r0);
    ssHigh();
    checkOutput("post_reset_master_rx", {24'd0, r0}, 32'h3C);
    checkOutput("post_reset_dout", {24'd0, dout_o}, 32'hC3);
    checkOutput("post_reset_ticks", rxTicks - ticksBefore, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
